// File: rtl/rggen_register_access_arbiter_if.sv
// Bus bundle between the host bridges and the shared register-access bus.
// The arbiter binds the slave modport. A host-side bench or wrapper binds
// the master modport.
interface rggen_register_access_arbiter_if #(
  parameter int HOSTS         = 2,
  parameter int REGISTERS     = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  // Host side: one command slot per host, shared response data/status.
  logic [HOSTS-1:0]                   host_valid;
  logic [HOSTS-1:0]                   host_accept;
  logic [HOSTS*ADDRESS_WIDTH-1:0]     host_address;
  logic [HOSTS-1:0]                   host_write;
  logic [HOSTS*DATA_WIDTH-1:0]        host_write_data;
  logic [HOSTS*(DATA_WIDTH/8)-1:0]    host_write_strobe;
  logic [HOSTS-1:0]                   host_done;
  logic [DATA_WIDTH-1:0]              host_read_data;
  logic [1:0]                         host_status;

  // Register side: a single request fans out, and per-register returns come back.
  logic                               reg_request;
  logic [ADDRESS_WIDTH-1:0]           reg_address;
  logic                               reg_direction;
  logic [DATA_WIDTH-1:0]              reg_write_data;
  logic [DATA_WIDTH/8-1:0]            reg_write_strobe;
  logic [REGISTERS-1:0]               reg_select;
  logic [REGISTERS-1:0]               reg_ready;
  logic [REGISTERS*DATA_WIDTH-1:0]    reg_read_data;
  logic [REGISTERS*2-1:0]             reg_status;

  modport slave (
    input  host_valid, host_address, host_write, host_write_data, host_write_strobe,
    input  reg_select, reg_ready, reg_read_data, reg_status,
    output host_accept, host_done, host_read_data, host_status,
    output reg_request, reg_address, reg_direction, reg_write_data, reg_write_strobe
  );

  modport master (
    output host_valid, host_address, host_write, host_write_data, host_write_strobe,
    output reg_select, reg_ready, reg_read_data, reg_status,
    input  host_accept, host_done, host_read_data, host_status,
    input  reg_request, reg_address, reg_direction, reg_write_data, reg_write_strobe
  );
endinterface

// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter that serialises host accesses onto the shared register
// bus. It handles one command at a time, folds the per-register
// select/ready/status returns into a single response, and flags decode
// errors and registers that never become ready.
module rggen_register_access_arbiter #(
  parameter int HOSTS          = 2,
  parameter int REGISTERS      = 4,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  rggen_register_access_arbiter_if.slave bus_if
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int GRANT_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1;
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);

  localparam logic [GRANT_WIDTH-1:0] LAST_HOST    = GRANT_WIDTH'(HOSTS - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST =
    COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;

  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'd2;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_RESPONSE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [GRANT_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [GRANT_WIDTH-1:0]   grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [STRB_WIDTH-1:0]    write_strobe_q, write_strobe_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic [1:0]               status_q, status_d;

  // Arbitration result
  logic                     pick_valid;
  logic [GRANT_WIDTH-1:0]   pick_index;
  logic [GRANT_WIDTH-1:0]   candidate;

  // Register-side return resolution
  logic [DATA_WIDTH-1:0]    masked_data   [REGISTERS];
  logic [1:0]               masked_status [REGISTERS];
  logic [DATA_WIDTH-1:0]    sel_read_data;
  logic [1:0]               sel_status;
  logic                     sel_ready;
  logic                     select_one_hot;

  // Handshake pulses
  logic                     accept_fire;
  logic                     done_fire;
  logic [HOSTS-1:0]         accept_vec;
  logic [HOSTS-1:0]         done_vec;

  // Round-robin search starting one past the last served host, wrapping at HOSTS.
  always_comb begin
    pick_valid = 1'b0;
    pick_index = '0;
    candidate  = last_grant_q;
    for (int k = 0; k < HOSTS; k++) begin
      candidate = (candidate == LAST_HOST) ? '0 : candidate + 1'b1;
      if (!pick_valid && bus_if.host_valid[candidate]) begin
        pick_valid = 1'b1;
        pick_index = candidate;
      end
    end
  end

  // Mask each register's returns by its own select. With a one-hot select,
  // OR-ing the masked values picks exactly the addressed register.
  for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_reg_mask
    assign masked_data[gi]   = bus_if.reg_select[gi]
                             ? bus_if.reg_read_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign masked_status[gi] = bus_if.reg_select[gi]
                             ? bus_if.reg_status[gi*2 +: 2] : 2'd0;
  end

  // Collapse the masked returns into a single data/status value for the selected register.
  always_comb begin
    sel_read_data = '0;
    sel_status    = 2'd0;
    for (int r = 0; r < REGISTERS; r++) begin
      sel_read_data = sel_read_data | masked_data[r];
      sel_status    = sel_status | masked_status[r];
    end
  end

  assign select_one_hot = (|bus_if.reg_select) &&
                          ((bus_if.reg_select & (bus_if.reg_select - 1'b1)) == '0);
  assign sel_ready      = |(bus_if.reg_select & bus_if.reg_ready);

  // Pulses are suppressed while reset is asserted, so an aborted access never reports completion.
  assign accept_fire = !rst && (state_q == ST_IDLE) && pick_valid;
  assign done_fire   = !rst && (state_q == ST_RESPONSE);

  for (genvar gi = 0; gi < HOSTS; gi++) begin : g_host_pulse
    assign accept_vec[gi] = accept_fire && (pick_index == GRANT_WIDTH'(gi));
    assign done_vec[gi]   = done_fire && (grant_q == GRANT_WIDTH'(gi));
  end

  // Next-state logic: latch the command on grant, resolve the access, and hand back the response.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    address_d      = address_q;
    write_d        = write_q;
    write_data_d   = write_data_q;
    write_strobe_d = write_strobe_q;
    count_d        = count_q;
    read_data_d    = read_data_q;
    status_d       = status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d        = pick_index;
          address_d      = bus_if.host_address[pick_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          write_d        = bus_if.host_write[pick_index];
          write_data_d   = bus_if.host_write_data[pick_index*DATA_WIDTH +: DATA_WIDTH];
          write_strobe_d = bus_if.host_write_strobe[pick_index*STRB_WIDTH +: STRB_WIDTH];
          count_d        = '0;
          state_d        = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
        // A bad decode takes precedence over ready, and ready takes precedence over the timeout.
        if (!select_one_hot) begin
          status_d    = STATUS_DECODE_ERROR;
          read_data_d = '0;
          state_d     = ST_RESPONSE;
        end else if (sel_ready) begin
          status_d    = sel_status;
          read_data_d = write_q ? '0 : sel_read_data;
          state_d     = ST_RESPONSE;
        end else if (TIMEOUT_ENABLE && (count_q == TIMEOUT_LAST)) begin
          status_d    = STATUS_SLAVE_ERROR;
          read_data_d = '0;
          state_d     = ST_RESPONSE;
        end
      end

      ST_RESPONSE: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset returns to IDLE with host 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= LAST_HOST;
      grant_q        <= '0;
      address_q      <= '0;
      write_q        <= 1'b0;
      write_data_q   <= '0;
      write_strobe_q <= '0;
      count_q        <= '0;
      read_data_q    <= '0;
      status_q       <= 2'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      address_q      <= address_d;
      write_q        <= write_d;
      write_data_q   <= write_data_d;
      write_strobe_q <= write_strobe_d;
      count_q        <= count_d;
      read_data_q    <= read_data_d;
      status_q       <= status_d;
    end
  end

  assign bus_if.host_accept      = accept_vec;
  assign bus_if.host_done        = done_vec;
  assign bus_if.host_read_data   = read_data_q;
  assign bus_if.host_status      = status_q;
  assign bus_if.reg_request      = (state_q == ST_ACCESS);
  assign bus_if.reg_address      = address_q;
  assign bus_if.reg_direction    = write_q;
  assign bus_if.reg_write_data   = write_data_q;
  assign bus_if.reg_write_strobe = write_strobe_q;

endmodule

// File: doc/rggen_register_access_arbiter.md
# rggen_register_access_arbiter

Sequences accesses from several bus hosts onto the shared register-access bus that fans out to the generated register blocks. Arbitrates between hosts round-robin, drives one request at a time, and resolves the per-register select/ready/status returns into a single response. Detects decode errors and hung registers. Sits between host bus bridges and the register array, inside the register-block top.

## Interface
- `HOSTS`, 2: number of requesting hosts, 1..8.
- `REGISTERS`, 4: number of register slaves on the bus, ≥1.
- `ADDRESS_WIDTH`, 16: byte address width.
- `DATA_WIDTH`, 32: data width, multiple of 8.
- `TIMEOUT_CYCLES`, 15: ACCESS cycles without ready before timeout; 0 disables the timeout.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `host_valid` input HOSTS: per-host command valid; held until accepted.
- `host_accept` output HOSTS: one-hot, one-cycle pulse accepting the command.
- `host_address` input HOSTS*ADDRESS_WIDTH: per-host address, host i in slice i.
- `host_write` input HOSTS: 1 = write, 0 = read.
- `host_write_data` input HOSTS*DATA_WIDTH: per-host write data.
- `host_write_strobe` input HOSTS*DATA_WIDTH/8: per-host byte strobes.
- `host_done` output HOSTS: one-hot, one-cycle response pulse to the granted host.
- `host_read_data` output DATA_WIDTH: response data, valid with `host_done`.
- `host_status` output 2: 0 OKAY, 1 EXOKAY, 2 SLAVE_ERROR, 3 DECODE_ERROR.
- `reg_request` output 1: access request to all registers.
- `reg_address` output ADDRESS_WIDTH: latched address.
- `reg_direction` output 1: 1 = write, 0 = read.
- `reg_write_data` output DATA_WIDTH: latched write data.
- `reg_write_strobe` output DATA_WIDTH/8: latched strobes.
- `reg_select` input REGISTERS: per-register address hit.
- `reg_ready` input REGISTERS: per-register access complete.
- `reg_read_data` input REGISTERS*DATA_WIDTH: per-register read data.
- `reg_status` input REGISTERS*2: per-register status, same encoding as `host_status`.

## Operation
- FSM states: IDLE, ACCESS, RESPONSE.
- IDLE:
  - If any `host_valid` is set, grant one host by round-robin. Priority starts at `last_grant+1` and wraps modulo HOSTS.
  - `last_grant` resets to HOSTS-1, so host 0 has first priority.
  - Pulse `host_accept[g]`.
  - Latch the address, direction, data and strobes into the command registers.
  - Go to ACCESS.
- ACCESS:
  - `reg_request`=1. `reg_*` driven from the command registers.
  - Timeout counter is cleared on entry and increments each ACCESS cycle. Width is $clog2(TIMEOUT_CYCLES+1) and it saturates.
  - Evaluated every cycle, first match wins:
    - 1) `reg_select` zero or not one-hot: status DECODE_ERROR, read data 0.
    - 2) `reg_ready[s]` of the selected register: status = `reg_status[s]`. Read data = `reg_read_data[s]` for reads, 0 for writes.
    - 3) Counter == TIMEOUT_CYCLES−1 and TIMEOUT_CYCLES≠0: status SLAVE_ERROR, read data 0.
  - On any match, register the response and go to RESPONSE. Otherwise stay.
- RESPONSE:
  - `host_done[g]`=1 for one cycle, with `host_read_data`/`host_status` held.
  - `last_grant`=g. Go to IDLE.
- Only the granted host's `host_accept`/`host_done` bit ever asserts.
- Host inputs are ignored outside IDLE. A host deasserting valid before accept loses nothing.

## Timing
- Reset values: state IDLE, `last_grant`=HOSTS−1, all outputs 0. This covers `reg_request`, `host_accept`, `host_done`, `host_read_data`, `host_status`, `reg_*`.
- Accept occurs in the IDLE cycle with valid. The first ACCESS cycle is the next cycle.
- Minimum latency is accept→done of 2 cycles (ready in the first ACCESS cycle). Throughput is at most one access per 3 cycles.
- The timeout fires after exactly TIMEOUT_CYCLES ACCESS cycles. `reg_request` then drops in RESPONSE. Late `reg_ready` is ignored.
- `reg_request` is high only in ACCESS. `reg_*` data outputs hold their latched values until the next accept.
- Reset mid-ACCESS or mid-RESPONSE: return to IDLE next cycle, no `host_done`, `reg_request`=0.
- Simultaneous valids are served in strict rotation. No host waits more than HOSTS−1 other accesses.

## Test plan
- **Single read:** host 0 reads 0x0004, register 1 selects with ready in the first ACCESS cycle, data 0xDEADBEEF, status OKAY -> `host_accept[0]` at cycle 0, `host_done[0]` at cycle 2, data 0xDEADBEEF, status 0.
- **Write with wait:** host 1 writes 0xA5A5A5A5 with strobe 0xF, register ready after 3 ACCESS cycles -> `reg_request` high for 3 cycles with stable `reg_*`, done at cycle 4, data 0, status 0.
- **Decode error:** read 0x0100, all `reg_select` 0 -> done at cycle 2, status 3, data 0. Two selects set -> same response.
- **Timeout:** TIMEOUT_CYCLES=15, selected register never readies -> `reg_request` high for exactly 15 cycles, status 2, done at cycle 16.
- **Round-robin:** HOSTS=3, all valids held high continuously -> grant order 0,1,2,0,1,2. Only host 2 valid after a host-1 grant -> host 2 granted immediately.
- **Reset mid-access:** `rst` for 1 cycle during ACCESS -> all outputs 0 next cycle, no done. A subsequent request completes normally with host 0 first priority.
